// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and the writeback port bundle for the writeback arbiter.
// Provides N, PHYS_REG_SZ_R10K, PHYS_TAG, DATA and WB_PACKET.
package wb_port_arbiter_pkg;

    // Number of regfile write ports and physical register file size.
    localparam int N                = 2;
    localparam int PHYS_REG_SZ_R10K = 64;

    localparam int TAG_W  = $clog2(PHYS_REG_SZ_R10K);
    localparam int DATA_W = 32;

    typedef logic [TAG_W-1:0]  PHYS_TAG;
    typedef logic [DATA_W-1:0] DATA;

    // One regfile write port worth of state.
    typedef struct packed {
        logic    valid;
        PHYS_TAG tag;
        DATA     data;
    } WB_PACKET;

endpackage

// File: rtl/wb_port_arbiter_rr_multi_select.sv
// Circular priority selector: picks up to N_WR set bits of valid_i,
// scanning from ptr_i upward. Ports: en_i, valid_i, ptr_i in;
// grant_o (one-hot per port), port_vld_o, any_o, last_idx_o out.
module rr_multi_select #(
    parameter int NUM_REQ = 4,
    parameter int N_WR    = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           en_i,
    input  logic [NUM_REQ-1:0]             valid_i,
    input  logic [PTR_W-1:0]               ptr_i,
    output logic [N_WR-1:0][NUM_REQ-1:0]   grant_o,
    output logic [N_WR-1:0]                port_vld_o,
    output logic                           any_o,
    output logic [PTR_W-1:0]               last_idx_o
);

    int idx;
    int cnt;

    always_comb begin
        grant_o    = '0;
        port_vld_o = '0;
        last_idx_o = '0;
        idx        = 0;
        cnt        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap the scan position without a modulo operator.
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en_i && valid_i[idx] && (cnt < N_WR)) begin
                grant_o[cnt][idx] = 1'b1;
                port_vld_o[cnt]   = 1'b1;
                last_idx_o        = PTR_W'(idx);
                cnt               = cnt + 1;
            end
        end
        any_o = port_vld_o[0];
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: grants up to N_WR completing requesters per cycle
// round-robin and drives registered regfile write ports.
// Ports: clock, reset, wb_stall, req_valid/tag/data in; req_ready,
// write_en, write_idx, write_data, grant_cnt out.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int N_WR    = N
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wb_stall,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]      req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [N_WR-1:0]               write_en,
    output logic [N_WR*TAG_W-1:0]         write_idx,
    output logic [N_WR*DATA_W-1:0]        write_data,
    output logic [$clog2(N_WR+1)-1:0]     grant_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(N_WR + 1);

    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [N_WR-1:0][NUM_REQ-1:0] grant;
    logic [N_WR-1:0]              port_vld;
    logic                         any_grant;
    logic [PTR_W-1:0]             last_idx;
    WB_PACKET                     wb_q [N_WR];
    WB_PACKET                     wb_d [N_WR];
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    PHYS_TAG                      tag_m;
    DATA                          data_m;

    rr_multi_select #(
        .NUM_REQ (NUM_REQ),
        .N_WR    (N_WR),
        .PTR_W   (PTR_W)
    ) u_sel (
        .en_i       (!reset && !wb_stall),
        .valid_i    (req_valid),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .port_vld_o (port_vld),
        .any_o      (any_grant),
        .last_idx_o (last_idx)
    );

    always_comb begin
        req_ready = '0;
        for (int p = 0; p < N_WR; p++) begin
            req_ready = req_ready | grant[p];
        end
    end

    always_comb begin
        cnt_d  = '0;
        tag_m  = '0;
        data_m = '0;
        for (int p = 0; p < N_WR; p++) begin
            tag_m  = '0;
            data_m = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                tag_m  = tag_m
                       | ({TAG_W{grant[p][i]}} & req_tag[i*TAG_W +: TAG_W]);
                data_m = data_m
                       | ({DATA_W{grant[p][i]}} & req_data[i*DATA_W +: DATA_W]);
            end
            // Tag 0 is the hardwired zero register: consume the slot,
            // suppress the write.
            wb_d[p].valid = port_vld[p] && (tag_m != '0);
            wb_d[p].tag   = wb_d[p].valid ? tag_m : '0;
            wb_d[p].data  = port_vld[p] ? data_m : '0;
            cnt_d         = cnt_d + CNT_W'(wb_d[p].valid);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (int'(last_idx) == NUM_REQ - 1)
                     ? '0 : last_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int p = 0; p < N_WR; p++) begin
                wb_q[p] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            for (int p = 0; p < N_WR; p++) begin
                wb_q[p] <= wb_d[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_WR; p++) begin
            write_en[p]                     = wb_q[p].valid;
            write_idx[p*TAG_W +: TAG_W]     = wb_q[p].tag;
            write_data[p*DATA_W +: DATA_W]  = wb_q[p].data;
        end
        grant_cnt = cnt_q;
    end

endmodule
